fifo_uart_tx: RTL and testbench



---
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/fifo_uart_tx.sv | 161 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle: the UART transmitter is the master (pops),
// the asynchronous FIFO read side is the slave (supplies data/empty).
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rden;
  logic [DATA_WIDTH-1:0] rddata;
  logic                  empty;

  modport master (
    output rden,
    input  rddata,
    input  empty
  );

  modport slave (
    input  rden,
    output rddata,
    output empty
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART transmitter, 8N1 frames in the FIFO read clock domain.
// Define FIFO_UART_TX_PARITY_EN to add an even-parity bit (8E1).
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic           rdclk,
  input  logic           rdrst,
  input  logic           tx_en,
  fifo_uart_tx_if.master rd,
  output logic           tx,
  output logic           busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IMAX = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  rden_q, rden_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign bit_end = (tmr_q == TMAX);

  always_ff @(posedge rdclk) begin
    if (rdrst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      rden_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      rden_q  <= rden_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
`ifdef FIFO_UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tx_en && !rd.empty) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        // FIFO presented the popped word on the FETCH edge
        sh_d    = rd.rddata;
        tmr_d   = '0;
        state_d = START;
`ifdef FIFO_UART_TX_PARITY_EN
        par_d   = ^rd.rddata;
`endif
      end
      START: begin
        tmr_d = tmr_q + TW'(1);
        if (bit_end) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tmr_d = tmr_q + TW'(1);
        if (bit_end) begin
          tmr_d = '0;
          sh_d  = sh_q >> 1;
          if (idx_q == IMAX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        tmr_d = tmr_q + TW'(1);
        if (bit_end) begin
          tmr_d   = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        tmr_d = tmr_q + TW'(1);
        if (bit_end) begin
          tmr_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it
  always_comb begin
    rden_d = (state_d == FETCH);
    busy_d = (state_d != IDLE);
    tx_d   = 1'b1;
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign rd.rden = rden_q;
  assign tx      = tx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO stub, per-cycle waveform model, directed
// scenarios with literal frame/timing expectations.
module tb_fifo_uart_tx;

  localparam int C = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [NB-1:0] A8_FRAME = 11'h750;
`else
  localparam int NB = 10;
  localparam logic [NB-1:0] A8_FRAME = 10'h350;
`endif
  localparam int PER = NB * C + 3;

  logic clk = 1'b0;
  logic rdrst;
  logic tx_en;
  logic tx;
  logic busy;

  fifo_uart_tx_if #(.DATA_WIDTH(8)) ifc ();

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(C)
  ) dut (
    .rdclk(clk),
    .rdrst(rdrst),
    .tx_en(tx_en),
    .rd   (ifc),
    .tx   (tx),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // FIFO stub: registered read data, pops on each sampled rden
  logic [7:0] mem [0:63];
  int wp = 0;
  int rp = 0;
  assign ifc.empty = (rp == wp);
  always @(posedge clk) begin
    if (ifc.rden === 1'b1) begin
      ifc.rddata <= mem[rp % 64];
      rp         <= rp + 1;
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wp % 64] = b;
    wp++;
  endtask

  // Model: expected {rden,busy,tx} per cycle as a queued waveform
  logic [2:0] exp_q[$];
  logic [2:0] cur = 3'b001;
  bit mvalid = 0;

  task automatic model_frame(input logic [7:0] b);
    exp_q.push_back(3'b111);
    exp_q.push_back(3'b011);
    repeat (C) exp_q.push_back(3'b010);
    for (int i = 0; i < 8; i++)
      repeat (C) exp_q.push_back({2'b01, b[i]});
`ifdef FIFO_UART_TX_PARITY_EN
    repeat (C) exp_q.push_back({2'b01, ^b});
`endif
    repeat (C) exp_q.push_back(3'b011);
    exp_q.push_back(3'b001);
  endtask

  always @(posedge clk) begin
    if (rdrst) begin
      exp_q.delete();
      cur = 3'b001;
    end else begin
      if (exp_q.size() == 0 && tx_en && !ifc.empty)
        model_frame(mem[rp % 64]);
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      else cur = 3'b001;
    end
    mvalid = 1;
  end

  always @(negedge clk) begin
    if (mvalid) chk("cycle", {29'd0, ifc.rden, busy, tx}, {29'd0, cur});
  end

  // Monitors: rden pulse log and tx-low cycle count
  int cyc = 0;
  int rden_cnt = 0;
  int low_cnt = 0;
  int rt [0:63];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (ifc.rden === 1'b1) begin
      rt[rden_cnt % 64] = cyc;
      rden_cnt++;
    end
    if (tx === 1'b0) low_cnt++;
  end

  // act: 1 = drop tx_en at sample k, 2 = assert reset at sample k
  task automatic rx_frame(input int act_k, input int act,
                          output logic [NB-1:0] bits);
    int n;
    n = 0;
    bits = '0;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL start_timeout act=no_start exp=start");
      return;
    end
    for (int k = 0; k < NB; k++) begin
      repeat ((k == 0) ? 1 : C) @(negedge clk);
      bits[k] = tx;
      if (k == act_k && act == 1) tx_en = 1'b0;
      if (k == act_k && act == 2) begin
        rdrst = 1'b1;
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rdrst = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  logic [NB-1:0] fb;
  logic [7:0] b2b [0:3];
  int base;
  int lc;

  initial begin
    b2b[0] = 8'hA8; b2b[1] = 8'h08; b2b[2] = 8'h68; b2b[3] = 8'h54;
    rdrst = 1'b1;
    tx_en = 1'b1;
    push(8'hA8);
    repeat (3) begin
      @(negedge clk);
      chk("rst_idle", {29'd0, ifc.rden, busy, tx}, 32'd1);
    end
    rdrst = 1'b0;
    @(negedge clk);
    chk("first_rden", {31'd0, ifc.rden}, 32'd1);
    rx_frame(-1, 0, fb);
    chk("a8_frame", 32'(fb), 32'(A8_FRAME));
    repeat (10) @(negedge clk);
    chk("a8_pulses", rden_cnt, 1);

    base = rden_cnt;
    for (int i = 0; i < 4; i++) push(b2b[i]);
    for (int i = 0; i < 4; i++) begin
      rx_frame(-1, 0, fb);
      chk("b2b_byte", {24'd0, fb[8:1]}, {24'd0, b2b[i]});
    end
    repeat (60) @(negedge clk);
    chk("b2b_pulses", rden_cnt - base, 4);
    for (int i = 0; i < 3; i++)
      chk("b2b_period", rt[base + i + 1] - rt[base + i], PER);
    chk("b2b_empty", {31'd0, ifc.empty}, 32'd1);

    base = rden_cnt;
    lc = low_cnt;
    repeat (100) @(negedge clk);
    chk("empty_rden", rden_cnt - base, 0);
    chk("empty_txlow", low_cnt - lc, 0);

    base = rden_cnt;
    push(8'h54);
    push(8'h33);
    rx_frame(4, 1, fb);
    chk("drop_byte", {24'd0, fb[8:1]}, 32'h54);
    repeat (30) @(negedge clk);
    chk("drop_pulses", rden_cnt - base, 1);
    chk("drop_notempty", {31'd0, ifc.empty}, 32'd0);
    tx_en = 1'b1;
    rx_frame(-1, 0, fb);
    chk("resume_byte", {24'd0, fb[8:1]}, 32'h33);

    push(8'h5A);
    push(8'hC3);
    rx_frame(6, 2, fb);
    rx_frame(-1, 0, fb);
    chk("post_rst_byte", {24'd0, fb[8:1]}, 32'hC3);
    repeat (60) @(negedge clk);
    chk("post_rst_empty", {31'd0, ifc.empty}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
